// File: rtl/fsmc_master.sv
// fsmc_master: single-beat async bus master, PRG space on ne1 and CHR space on ne2.
// Optional nwait timeout is compiled in with `define FSMC_MASTER_WAIT_TIMEOUT_EN.
module fsmc_master #(
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned STROBE_CYCLES  = 4,
   parameter int unsigned HOLD_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        master_clock,
   input  logic        nrst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_chr,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_error,
   output logic        ne1,
   output logic        ne2,
   output logic        noe,
   output logic        nwe,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   input  logic        nwait
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic [7:0] LP_SETUP  = 8'(SETUP_CYCLES);
   localparam logic [7:0] LP_STROBE = 8'(STROBE_CYCLES);
   localparam logic [7:0] LP_HOLD   = 8'(HOLD_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  w_cnt_inc;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic        r_write;
   logic        r_chr;
   logic        r_armed;
   logic        r_nw1;
   logic        r_nw2;
   logic        w_nwait_s;
   logic        w_accept;
   logic        w_strobe_end;
   logic        w_capture;
   logic        w_busy;

`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
   localparam logic [7:0] LP_TO = 8'(TIMEOUT_CYCLES);
   logic [7:0] r_wcnt;
   logic [7:0] w_wcnt_nxt;
   logic       r_err;
   logic       w_timeout;
`endif

   assign w_nwait_s = r_nw2;
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   always_ff @(posedge master_clock or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_nxt    = w_cnt_inc;
      w_accept     = 1'b0;
      w_strobe_end = 1'b0;
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
      w_timeout    = 1'b0;
      w_wcnt_nxt   = 8'd0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = 8'd1;
            if (cmd_valid && r_armed) begin
               w_accept = 1'b1;
               w_next   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt >= LP_SETUP) begin
               w_next    = ST_STROBE;
               w_cnt_nxt = 8'd1;
            end
         end
         ST_STROBE: begin
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
            w_wcnt_nxt = r_wcnt;
`endif
            if (r_cnt >= LP_STROBE) begin
               if (w_nwait_s) w_strobe_end = 1'b1;
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
               else if (r_wcnt >= LP_TO) begin
                  w_strobe_end = 1'b1;
                  w_timeout    = 1'b1;
               end else if (r_wcnt != 8'hFF) begin
                  w_wcnt_nxt = r_wcnt + 8'd1;
               end
`endif
            end
            if (w_strobe_end) begin
               w_next    = ST_HOLD;
               w_cnt_nxt = 8'd1;
            end
         end
         ST_HOLD: begin
            if (r_cnt >= LP_HOLD) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
   assign w_capture = w_strobe_end && !r_write && !w_timeout;
`else
   assign w_capture = w_strobe_end && !r_write;
`endif

   always_ff @(posedge master_clock or negedge nrst) begin
      if (!nrst) begin
         r_cnt   <= 8'd0;
         r_addr  <= 16'd0;
         r_wdata <= 8'd0;
         r_rdata <= 8'd0;
         r_write <= 1'b0;
         r_chr   <= 1'b0;
         r_armed <= 1'b0;
         r_nw1   <= 1'b1;
         r_nw2   <= 1'b1;
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
         r_wcnt  <= 8'd0;
         r_err   <= 1'b0;
`endif
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_armed <= 1'b1;
         r_nw1   <= nwait;
         r_nw2   <= r_nw1;
         if (w_accept) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_write <= cmd_write;
            r_chr   <= cmd_chr;
         end
         if (w_capture) r_rdata <= data_in;
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
         r_wcnt <= w_wcnt_nxt;
         if (w_accept) r_err <= 1'b0;
         else if (w_timeout) r_err <= 1'b1;
`endif
      end
   end

   assign w_busy    = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                      (r_state == ST_HOLD);
   assign ne1       = !(w_busy && !r_chr);
   assign ne2       = !(w_busy && r_chr);
   assign noe       = !((r_state == ST_STROBE) && !r_write);
   assign nwe       = !((r_state == ST_STROBE) && r_write);
   assign data_oe   = w_busy && r_write;
   assign rsp_valid = (r_state == ST_DONE);
   assign cmd_ready = (r_state == ST_IDLE) && r_armed;
   assign addr      = r_addr;
   assign data_out  = r_wdata;
   assign rsp_rdata = r_rdata;

`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
   assign rsp_error = (r_state == ST_DONE) && r_err;
`else
   // No timeout hardware: the parameter is kept only so both builds share one port/param list.
   localparam bit LP_TO_KEEP = (TIMEOUT_CYCLES > 0);
   assign rsp_error = LP_TO_KEEP & 1'b0;
`endif

endmodule

// File: tb/tb_fsmc_master.sv
// tb_fsmc_master: randomized transactions checked cycle-by-cycle against a phase-boundary model.
// Covers reset, PRG/CHR reads and writes, nwait stretch, abort, back-to-back and optional timeout.
module tb_fsmc_master;

   localparam int S  = 2;
   localparam int T  = 4;
   localparam int H  = 2;
   localparam int TO = 20;

   logic        master_clock = 1'b0;
   logic        nrst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic        cmd_chr = 1'b0;
   logic [15:0] cmd_addr = 16'd0;
   logic [7:0]  cmd_wdata = 8'd0;
   logic [7:0]  data_in = 8'd0;
   logic        nwait = 1'b1;
   logic        cmd_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_error;
   logic        ne1, ne2, noe, nwe;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        data_oe;

   int checks = 0;
   int failures = 0;
   logic [7:0] m_rdata = 8'd0;

   fsmc_master #(
      .SETUP_CYCLES(S), .STROBE_CYCLES(T),
      .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)
   ) dut (
      .master_clock(master_clock), .nrst(nrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_chr(cmd_chr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .ne1(ne1), .ne2(ne2), .noe(noe), .nwe(nwe),
      .addr(addr), .data_out(data_out), .data_oe(data_oe),
      .data_in(data_in), .nwait(nwait)
   );

   always #5 master_clock = ~master_clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // nwait is low during cycles [lo, lo+len) counted from the acceptance edge
   function automatic logic nw_at(input int c, input int lo, input int len);
      return !(len > 0 && c >= lo && c < lo + len);
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge master_clock); #1;
      end
   endtask

   task automatic run_txn(input bit wr, input bit chr, input logic [15:0] a,
                          input logic [7:0] wd, input int lo, input int len,
                          input int din_fix, input string tag, output int done_c);
      int e;
      int dn;
      int ph;
      bit err;
      bit sy;
      bit ok;
      bit busy;
      logic [7:0] din_e;
      logic [6:0] ev, ov;
      e = -1;
      err = 1'b0;
      din_e = 8'd0;
      done_c = -1;
      for (int c = S + T; c < 400; c++) begin
         sy = (c - 2 <= 0) ? 1'b1 : nw_at(c - 2, lo, len);
         if (sy) begin
            e = c;
            break;
         end
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
         if (c == S + T + TO) begin
            e = c;
            err = 1'b1;
            break;
         end
`endif
      end
      if (e < 0) begin
         checks++;
         failures++;
         $display("FAIL %s model: strobe never ends got=%0d want=bounded", tag, e);
         return;
      end
      dn = e + H + 1;
      wait_ready(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s ready_wait got=%b want=1", tag, cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_chr   = chr;
      cmd_addr  = a;
      cmd_wdata = wd;
      nwait     = 1'b1;
      data_in   = 8'($urandom);
      @(posedge master_clock); #1;
      for (int c = 1; c <= dn + 1; c++) begin
         ph = (c <= S) ? 0 : (c <= e) ? 1 : (c <= e + H) ? 2 : (c == dn) ? 3 : 4;
         busy = (ph <= 2);
         ev = {!(busy && !chr), !(busy && chr), !(ph == 1 && !wr),
               !(ph == 1 && wr), busy && wr, ph == 3, ph == 4};
         ov = {ne1, ne2, noe, nwe, data_oe, rsp_valid, cmd_ready};
         checks++;
         if (ov !== ev) begin
            failures++;
            $display("FAIL %s cyc%0d strobes{ne1,ne2,noe,nwe,oe,rv,rdy} got=%b want=%b",
                     tag, c, ov, ev);
         end
         checks++;
         if ({addr, data_out} !== {a, wd}) begin
            failures++;
            $display("FAIL %s cyc%0d addr/data_out got=%h/%h want=%h/%h",
                     tag, c, addr, data_out, a, wd);
         end
         if (ph == 3) begin
            if (!wr && !err) m_rdata = din_e;
            checks++;
            if ({rsp_rdata, rsp_error} !== {m_rdata, err}) begin
               failures++;
               $display("FAIL %s done rdata/err got=%h/%b want=%h/%b",
                        tag, rsp_rdata, rsp_error, m_rdata, err);
            end
         end
         nwait = nw_at(c, lo, len);
         data_in = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
         if (c == e) din_e = data_in;
         cmd_valid = (c < dn) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_write = 1'($urandom);
         cmd_chr   = 1'($urandom);
         cmd_addr  = 16'($urandom);
         cmd_wdata = 8'($urandom);
         if (c <= dn) begin
            @(posedge master_clock); #1;
         end
      end
      nwait = 1'b1;
      done_c = dn;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(posedge master_clock);
      #1;
      checks++;
      if ({ne1, ne2, noe, nwe, data_oe, cmd_ready, rsp_valid, rsp_error} !== 8'b1111_0000) begin
         failures++;
         $display("FAIL reset strobes got=%b want=11110000",
                  {ne1, ne2, noe, nwe, data_oe, cmd_ready, rsp_valid, rsp_error});
      end
      checks++;
      if ({addr, data_out, rsp_rdata} !== 32'd0) begin
         failures++;
         $display("FAIL reset data got=%h/%h/%h want=0/0/0", addr, data_out, rsp_rdata);
      end
      @(negedge master_clock);
      nrst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset ready_before_edge got=%b want=0", cmd_ready);
      end
      @(posedge master_clock); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset ready_after_edge got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_prg_read();
      int dn;
      run_txn(1'b0, 1'b0, 16'h8000, 8'($urandom), 0, 0, 8'h5A, "prg_read", dn);
      checks++;
      if (dn !== 9 || rsp_rdata !== 8'h5A) begin
         failures++;
         $display("FAIL prg_read latency/rdata got=%0d/%h want=9/5a", dn, rsp_rdata);
      end
   endtask

   task automatic test_chr_write();
      int dn;
      run_txn(1'b1, 1'b1, 16'h0123, 8'hC3, 0, 0, -1, "chr_write", dn);
      checks++;
      if (dn !== 9) begin
         failures++;
         $display("FAIL chr_write latency got=%0d want=9", dn);
      end
   endtask

   task automatic test_wait_stretch();
      int dn;
      run_txn(1'b0, 1'b0, 16'($urandom), 8'($urandom), S + 1, 10, -1, "wait_stretch", dn);
      checks++;
      if (dn < 17) begin
         failures++;
         $display("FAIL wait_stretch latency got=%0d want>=17", dn);
      end
   endtask

   task automatic test_random();
      int dn;
      for (int i = 0; i < 14; i++) begin
         run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                 $urandom_range(1, 12), $urandom_range(0, 8), -1, "random", dn);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a1, a2;
      logic [7:0] d;
      bit ok;
      a1 = 16'($urandom);
      a2 = 16'($urandom);
      d  = 8'($urandom);
      wait_ready(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL b2b ready_wait got=%b want=1", cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_chr   = 1'b0;
      cmd_addr  = a1;
      data_in   = d;
      nwait     = 1'b1;
      @(posedge master_clock); #1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 9 || c == 19) begin
            checks++;
            if ({rsp_valid, rsp_rdata} !== {1'b1, d}) begin
               failures++;
               $display("FAIL b2b cyc%0d rsp got=%b/%h want=1/%h", c, rsp_valid, rsp_rdata, d);
            end
         end
         if (c == 10) begin
            checks++;
            if ({cmd_ready, ne1, rsp_valid, addr} !== {3'b110, a1}) begin
               failures++;
               $display("FAIL b2b gap got=%b%b%b/%h want=110/%h",
                        cmd_ready, ne1, rsp_valid, addr, a1);
            end
         end
         if (c == 11) begin
            checks++;
            if ({cmd_ready, ne1, addr} !== {2'b00, a2}) begin
               failures++;
               $display("FAIL b2b second_accept got=%b%b/%h want=00/%h",
                        cmd_ready, ne1, addr, a2);
            end
         end
         if (c == 20) begin
            checks++;
            if ({cmd_ready, rsp_valid, ne1} !== 3'b101) begin
               failures++;
               $display("FAIL b2b end got=%b want=101", {cmd_ready, rsp_valid, ne1});
            end
         end
         if (c == 1) cmd_addr = a2;
         if (c == 11) cmd_valid = 1'b0;
         if (c < 20) begin
            @(posedge master_clock); #1;
         end
      end
      m_rdata = d;
   endtask

   task automatic test_abort();
      bit ok;
      bit seen;
      wait_ready(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL abort ready_wait got=%b want=1", cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_chr   = 1'b0;
      cmd_addr  = 16'($urandom);
      cmd_wdata = 8'($urandom);
      nwait     = 1'b1;
      @(posedge master_clock); #1;
      cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge master_clock); #1;
      end
      checks++;
      if ({nwe, data_oe} !== 2'b01) begin
         failures++;
         $display("FAIL abort in_strobe got=%b want=01", {nwe, data_oe});
      end
      #2;
      nrst = 1'b0;
      #1;
      m_rdata = 8'd0;
      checks++;
      if ({ne1, ne2, noe, nwe, data_oe, rsp_valid, cmd_ready} !== 7'b1111000) begin
         failures++;
         $display("FAIL abort immediate got=%b want=1111000",
                  {ne1, ne2, noe, nwe, data_oe, rsp_valid, cmd_ready});
      end
      checks++;
      if ({addr, rsp_rdata} !== 24'd0) begin
         failures++;
         $display("FAIL abort regs got=%h/%h want=0/0", addr, rsp_rdata);
      end
      repeat (2) @(posedge master_clock);
      @(negedge master_clock);
      nrst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort ready_before_edge got=%b want=0", cmd_ready);
      end
      @(posedge master_clock); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort ready_after_edge got=%b want=1", cmd_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid === 1'b1 || ne1 === 1'b0) seen = 1'b1;
         @(posedge master_clock); #1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL abort stray_activity got=%b want=0", seen);
      end
   endtask

`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
   task automatic test_timeout();
      int dn;
      run_txn(1'b0, 1'b1, 16'($urandom), 8'($urandom), 1, 1000, -1, "timeout", dn);
      checks++;
      if (dn !== S + T + TO + H + 1) begin
         failures++;
         $display("FAIL timeout latency got=%0d want=%0d", dn, S + T + TO + H + 1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_prg_read();
      test_chr_write();
      test_wait_stretch();
      test_random();
      test_back_to_back();
      test_abort();
`ifdef FSMC_MASTER_WAIT_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
